// File: rtl/ccg_bist_ctrl_pkg.sv
// Shared constants and types for the BIST controller.
package ccg_bist_ctrl_pkg;

  localparam int unsigned BIST_SIG_W = 16;
  localparam int unsigned BIST_CNT_W = 16;
  localparam int unsigned BIST_LFSR_W = 24;

  // MISR feedback polynomial (CRC-16-CCITT).
  localparam logic [BIST_SIG_W-1:0] BIST_MISR_POLY = 16'h1021;

  // LFSR tap mask: taps 24,23,22,17 map to bits 23,22,21,16.
  localparam logic [BIST_LFSR_W-1:0] BIST_LFSR_TAPS = 24'hE1_0000;

  typedef enum logic [1:0] {
    BIST_IDLE = 2'd0,
    BIST_RUN  = 2'd1,
    BIST_DONE = 2'd2
  } bist_state_e;

endpackage

// File: rtl/ccg_bist_ctrl_misr.sv
// Response compactor: 16-bit MISR with compact-enable and synchronous clear.
module bist_misr
  import ccg_bist_ctrl_pkg::*;
#(
  parameter int unsigned N_OUT = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [N_OUT-1:0]      din,
  output logic [BIST_SIG_W-1:0] sig,
  output logic [BIST_SIG_W-1:0] sig_next_c
);

  // Next MISR value if a compaction happens at the coming edge.
  always_comb begin
    sig_next_c = {sig[BIST_SIG_W-2:0], 1'b0}
               ^ (sig[BIST_SIG_W-1] ? BIST_MISR_POLY : BIST_SIG_W'(0))
               ^ BIST_SIG_W'(din);
  end

  // Signature register; clear wins over compaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next_c;
    end
  end

endmodule

// File: rtl/ccg_bist_ctrl.sv
// BIST controller: LFSR stimulus, pattern counter, FSM and MISR-based pass/fail.
module ccg_bist_ctrl
  import ccg_bist_ctrl_pkg::*;
#(
  parameter int unsigned    N_IN  = 24,
  parameter int unsigned    N_OUT = 14,
  parameter logic [N_IN-1:0] SEED = N_IN'(1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIST_CNT_W-1:0] num_pat,
  input  logic [BIST_SIG_W-1:0] golden_sig,
  output logic [N_IN-1:0]       dut_in,
  input  logic [N_OUT-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [BIST_SIG_W-1:0] signature
);

  bist_state_e           state_q, state_d;
  logic                  accept_c;
  logic                  compact_c;
  logic                  last_c;
  logic [BIST_CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]       lfsr_q, lfsr_d;
  logic                  busy_d, done_d, pass_d;
  logic [BIST_SIG_W-1:0] misr_next_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BIST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    unique case (state_q)
      BIST_IDLE, BIST_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = (num_pat != '0) ? BIST_RUN : BIST_DONE;
        end
      end
      BIST_RUN: begin
        if (cnt_q == BIST_CNT_W'(1)) state_d = BIST_DONE;
      end
      default: state_d = BIST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    compact_c = (state_q == BIST_RUN);
    last_c    = compact_c && (cnt_q == BIST_CNT_W'(1));
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    pass_d    = pass;
    busy_d    = (state_d == BIST_RUN);
    done_d    = (state_d == BIST_DONE);
    if (accept_c) begin
      cnt_d  = num_pat;
      lfsr_d = (num_pat != '0) ? SEED : '0;
      pass_d = (num_pat == '0) && (golden_sig == '0);
    end else if (compact_c) begin
      cnt_d  = cnt_q - BIST_CNT_W'(1);
      lfsr_d = last_c ? '0
                      : {lfsr_q[N_IN-2:0], ^(lfsr_q & N_IN'(BIST_LFSR_TAPS))};
      if (last_c) pass_d = (misr_next_c == golden_sig);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lfsr_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      busy   <= busy_d;
      done   <= done_d;
      pass   <= pass_d;
    end
  end

  // LFSR is zero outside RUN, so it drives the DUT directly.
  assign dut_in = lfsr_q;

  bist_misr #(
    .N_OUT (N_OUT)
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept_c),
    .en         (compact_c),
    .din        (dut_out),
    .sig        (signature),
    .sig_next_c (misr_next_c)
  );

endmodule

// File: tb/tb_ccg_bist_ctrl.sv
// Self-checking bench for ccg_bist_ctrl with a behavioural reference model.
module tb_ccg_bist_ctrl;

  localparam logic [23:0] SEED = 24'h000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_pat;
  logic [15:0] golden_sig;
  logic [23:0] dut_in;
  logic [13:0] dut_out;
  logic        busy, done, pass;
  logic [15:0] signature;

  // Circuit-under-test emulation.
  logic        loop_mode;
  logic [13:0] const_out;
  logic        flip_en;
  logic [23:0] flip_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ccg_bist_ctrl #(.N_IN(24), .N_OUT(14), .SEED(SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pat    (num_pat),
    .golden_sig (golden_sig),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
  );

  always_comb begin
    if (loop_mode)
      dut_out = dut_in[13:0] ^ ((flip_en && dut_in == flip_vec) ? 14'd1 : 14'd0);
    else
      dut_out = const_out;
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] m_lfsr(input logic [23:0] v);
    int taps[4] = '{24, 23, 22, 17};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= v[taps[t]-1];
    return {v[22:0], fb};
  endfunction

  // Multiply by x modulo x^16+x^12+x^5+1, then add the response.
  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [13:0] r);
    logic [16:0] prod = {s, 1'b0};
    if (prod[16]) prod ^= 17'h11021;
    return prod[15:0] ^ {2'b00, r};
  endfunction

  function automatic logic [13:0] m_resp(input logic [23:0] v, input bit lp,
                                         input logic [13:0] c, input bit fe,
                                         input logic [23:0] fv);
    if (!lp) return c;
    return v[13:0] ^ ((fe && v == fv) ? 14'd1 : 14'd0);
  endfunction

  function automatic logic [15:0] m_sig(input int n, input bit lp, input logic [13:0] c,
                                        input bit fe, input logic [23:0] fv);
    logic [23:0] v = SEED;
    logic [15:0] s = '0;
    for (int i = 0; i < n; i++) begin
      s = m_misr(s, m_resp(v, lp, c, fe, fv));
      v = m_lfsr(v);
    end
    return s;
  endfunction

  function automatic logic [23:0] m_pat(input int idx);  // 1-based pattern
    logic [23:0] v = SEED;
    for (int i = 1; i < idx; i++) v = m_lfsr(v);
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one test from a negedge, checking every pattern cycle and the final result.
  task automatic run_test(input string tag, input int n, input logic [15:0] gold,
                          input logic [15:0] exp_sig, input logic exp_pass,
                          input bit mid_start);
    logic [23:0] v = SEED;
    int          bad = 0;
    start = 1'b1; num_pat = 16'(n); golden_sig = gold;
    @(negedge clk);
    start = 1'b0; num_pat = 16'hBEEF;
    for (int i = 1; i <= n; i++) begin
      if (dut_in !== v || busy !== 1'b1 || done !== 1'b0) bad++;
      if (mid_start && i == 2) begin start = 1'b1; num_pat = 16'd2; end
      else if (mid_start && i == 3) start = 1'b0;
      v = m_lfsr(v);
      @(negedge clk);
    end
    start = 1'b0;
    if (n > 0) chk({tag, " run_cycles_bad"}, 32'(bad), 32'd0);
    chk({tag, " done"},      {30'd0, busy, done}, 32'h1);
    chk({tag, " dut_in"},    32'(dut_in), 32'd0);
    chk({tag, " signature"}, 32'(signature), 32'(exp_sig));
    chk({tag, " pass"},      32'(pass), 32'(exp_pass));
    golden_sig = ~gold;
    repeat (3) @(negedge clk);
    chk({tag, " hold"}, {14'd0, busy, done, pass, signature},
        {14'd0, 1'b0, 1'b1, exp_pass, exp_sig});
  endtask

  typedef struct {
    int          n;
    logic [13:0] cout;
    logic [15:0] gold;
    logic [15:0] sig;
    logic        pass;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] s;
    vec_t e;

    rst_n = 1'b0; start = 1'b0; num_pat = '0; golden_sig = '0;
    loop_mode = 1'b0; const_out = '0; flip_en = 1'b0; flip_vec = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {6'd0, busy, done, pass, signature, dut_in[0]}, 32'd0);
    chk("reset_dut_in", 32'(dut_in), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    // Directed vectors with hand-derived expectations.
    tbl.push_back('{1, 14'h0000, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{2, 14'h0001, 16'h0004, 16'h0003, 1'b0});
    tbl.push_back('{0, 14'h0000, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{0, 14'h0000, 16'h0005, 16'h0000, 1'b0});
    tbl.push_back('{2, 14'h0001, 16'h0003, 16'h0003, 1'b1});
    tbl.push_back('{3, 14'h0001, 16'h0007, 16'h0007, 1'b1});
    tbl.push_back('{2, 14'h3FFF, 16'h4001, 16'h4001, 1'b1});
    // Random vectors scored by the model.
    for (int i = 0; i < 8; i++) begin
      e.n    = int'($urandom_range(1, 40));
      e.cout = 14'($urandom);
      s      = m_sig(e.n, 1'b0, e.cout, 1'b0, '0);
      e.gold = ($urandom_range(0, 1) == 1) ? s : 16'($urandom);
      e.sig  = s;
      e.pass = (e.gold == s);
      tbl.push_back(e);
    end

    foreach (tbl[i]) begin
      const_out = tbl[i].cout;
      run_test($sformatf("vec%0d", i), tbl[i].n, tbl[i].gold, tbl[i].sig, tbl[i].pass, 1'b0);
    end

    // Start pulse during RUN must not disturb the run.
    const_out = 14'h0055;
    s = m_sig(5, 1'b0, 14'h0055, 1'b0, '0);
    run_test("mid_start", 5, s, s, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a run.
    const_out = 14'h0123;
    start = 1'b1; num_pat = 16'd20; golden_sig = 16'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {29'd0, busy, done, pass}, 32'd0);
    chk("async_reset_sig", 32'(signature), 32'd0);
    chk("async_reset_dut_in", 32'(dut_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, done}, 32'd0);
    s = m_sig(3, 1'b0, 14'h0123, 1'b0, '0);
    run_test("after_reset", 3, s, s, 1'b1, 1'b0);

    // Loopback, clean and with one corrupted response at pattern 500.
    loop_mode = 1'b1;
    s = m_sig(1000, 1'b1, '0, 1'b0, '0);
    run_test("loop_clean", 1000, s, s, 1'b1, 1'b0);
    flip_vec = m_pat(500);
    flip_en  = 1'b1;
    run_test("loop_flip", 1000, s, m_sig(1000, 1'b1, '0, 1'b1, flip_vec), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccg_bist_ctrl.md
# ccg_bist_ctrl

Built-in self-test controller for the team's generated combinational benchmark circuits (24 primary inputs, 14 primary outputs). It drives pseudo-random input vectors into the circuit under test from a 24-bit LFSR and receives the 14-bit response. It compacts the responses into a 16-bit MISR signature and compares that signature against a golden value. It sits between the benchmark netlist and the dataset-collection test harness. All DUT logic stays external; this block only generates stimulus and analyses responses.

## Interface
- `N_IN`, 24: width of the stimulus vector (fixed LFSR width).
- `N_OUT`, 14: width of the DUT response. Must be ≤ 16.
- `SEED`, 24'h000001: LFSR load value on start. Must be nonzero.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a test. Sampled only in IDLE or DONE.
- `num_pat`  in  16  number of patterns to apply. Latched on accepted start.
- `golden_sig`  in  16  expected signature. Sampled at the end of RUN.
- `dut_in`  out  24  registered stimulus to the DUT.
- `dut_out`  in  14  combinational DUT response to `dut_in`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `pass`  out  1  signature matched golden. Valid while `done`.
- `signature`  out  16  current MISR contents.

## Operation
- The FSM has three states:
  - IDLE → RUN on `start` when `num_pat` != 0.
  - IDLE → DONE on `start` when `num_pat` == 0.
  - RUN → DONE after `num_pat` compactions.
  - DONE → RUN or DONE on a new `start`, using the same rules as IDLE.
- Accepted start (at that edge):
  - Load LFSR with `SEED`.
  - Clear MISR to 0.
  - Load counter with `num_pat`.
- LFSR is a Fibonacci left-shift: next = {lfsr[22:0], lfsr[23]^lfsr[22]^lfsr[21]^lfsr[16]} (taps 24,23,22,17).
- MISR: next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ zero-extended `dut_out`.
- Every RUN cycle, at the same edge:
  - MISR compacts `dut_out`.
  - LFSR advances.
  - Counter decrements.
- On the edge where the counter decrements from 1:
  - Go to DONE.
  - Register `pass` = (next MISR value == `golden_sig`).
  - Force `dut_in` to 0.
- `dut_in` is the LFSR register during RUN and 0 in IDLE and DONE. The LFSR is cleared on leaving RUN.
- `start` during RUN is ignored.
- `num_pat` == 0: go straight to DONE with `signature` = 0 and `pass` = (`golden_sig` == 0).
- `signature` and `pass` hold in DONE until the next accepted start.

## Timing
- All outputs are registered.
- Reset values: `dut_in` = 0, `busy` = 0, `done` = 0, `pass` = 0, `signature` = 0, state IDLE.
- Start accepted at edge k:
  - `busy` = 1 and `dut_in` = `SEED` from k+1.
  - First compaction at edge k+1.
- Pattern i (1-based) is compacted at edge k+i.
- `done` rises at edge k+`num_pat`, in the same cycle `busy` falls.
- Total latency from start to `done` is `num_pat` cycles (`num_pat` = 0: 1 cycle).
- `rst_n` assertion mid-RUN clears everything immediately (asynchronous). No partial result is reported.
- The counter is 16-bit. `num_pat` = 16'hFFFF runs 65535 patterns; no wrap occurs.

## Structure
- Shared package holds:
  - `BIST_MISR_POLY` = 16'h1021
  - `BIST_LFSR_TAPS`
  - the state enum {IDLE, RUN, DONE}
- One natural sub-module, `bist_misr`: MISR register with compact-enable and synchronous clear. The LFSR, counter and FSM stay in the top level.

## Test plan
- `num_pat`=1, `dut_out` tied 0 → `dut_in` = 24'h000001 for one cycle; `done` after 1 cycle; `signature` = 16'h0000; `pass` = 1 with `golden_sig` = 0.
- `num_pat`=2, `dut_out` = 14'h0001 constant → `dut_in` sequence 000001, 000002; `signature` = 16'h0003; `pass` = 0 with `golden_sig` = 16'h0004.
- `num_pat`=0, `golden_sig`=0 → DONE one cycle after start; `busy` never high; `signature` = 0; `pass` = 1.
- Start pulse during RUN with `num_pat`=5 → run length unchanged; `done` exactly 5 cycles after the original start.
- `rst_n` low mid-RUN → all outputs 0 immediately; state IDLE; a new start re-runs from `SEED`.
- Loopback `dut_out` = `dut_in[13:0]`, `num_pat`=1000 → signature matches the reference-model value; a single bit flip injected in pattern 500 → `pass` = 0.
